// File: rtl/zxuno_regport_pkg.sv
// zxuno_regport_pkg
// Shared configuration for the ZX-Uno register port front end and the
// register blocks hanging off it: default I/O port addresses, the value
// the register-select latch takes on reset, the address-port value that
// arms auto-increment (ZXUNO_ADDR_AUTOINC_EN builds), the front-end FSM
// state encoding and register numbers already decoded downstream.
package zxuno_regport_pkg;

    localparam logic [15:0] ADDR_PORT_DEFAULT = 16'hFC3B;
    localparam logic [15:0] DATA_PORT_DEFAULT = 16'hFD3B;
    localparam logic [7:0]  RST_ADDR_DEFAULT  = 8'h00;

    // Address-port value that arms auto-increment instead of selecting a register
    localparam logic [7:0]  AUTOINC_SELECT    = 8'hFE;

    // Register numbers decoded by downstream blocks
    localparam logic [7:0]  REG_DEVOPTIONS    = 8'h0E;
    localparam logic [7:0]  REG_COREID        = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WPULSE  = 2'd1,
        ST_WWAIT   = 2'd2,
        ST_RACTIVE = 2'd3
    } regport_state_t;

endpackage

// File: rtl/zxuno_regport_if.sv
// zxuno_regport_if
// Z80 I/O bus as seen by the register port.
//   a, iorq_n, m1_n, rd_n, wr_n, din : driven by the CPU side (master)
//   dout, oe                         : address-port readback (slave)
interface zxuno_regport_if;

    logic [15:0] a;
    logic        iorq_n;
    logic        m1_n;
    logic        rd_n;
    logic        wr_n;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        oe;

    modport master (
        output a, iorq_n, m1_n, rd_n, wr_n, din,
        input  dout, oe
    );

    modport slave (
        input  a, iorq_n, m1_n, rd_n, wr_n, din,
        output dout, oe
    );

endinterface

// File: rtl/zxuno_strobe_edge.sv
// zxuno_strobe_edge
// Registers one active-low CPU strobe and flags its falling edge.
//   clk, rst_n : clock, asynchronous active-low reset
//   strobe_n   : raw strobe, synchronous to clk
//   fall       : high while strobe_n is low and its previous sample was high
module zxuno_strobe_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe_n,
    output logic fall
);

    logic strobe_q;

    // Reset to "previously low": a strobe already held low when reset
    // releases must not be mistaken for a fresh falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= strobe_n;
        end
    end

    assign fall = strobe_q && !strobe_n;

endmodule

// File: rtl/zxuno_regport.sv
// zxuno_regport
// Z80-facing front end of the ZX-Uno extended register bank. Decodes the
// register-select port and the register-data port, holds the select latch
// and produces clean read/write strobes for downstream register blocks.
//   clk, rst_n    : clock, asynchronous active-low reset
//   bus           : CPU I/O bus (slave modport); dout/oe return the select
//                   latch on address-port reads, FFh/0 otherwise
//   zxuno_addr    : current register-select latch
//   zxuno_regrd   : level, high while a data-port read is in progress
//   zxuno_regwr   : one-cycle data-port write strobe
//   zxuno_wrdata  : data captured for the write strobe
// Build option ZXUNO_ADDR_AUTOINC_EN adds regaddr_autoinc_active: writing
// FEh to the address port arms auto-increment of zxuno_addr after every
// data-port transfer; any other address write disarms it.
module zxuno_regport
    import zxuno_regport_pkg::*;
#(
    parameter logic [15:0] ADDR_PORT = ADDR_PORT_DEFAULT,
    parameter logic [15:0] DATA_PORT = DATA_PORT_DEFAULT,
    parameter logic [7:0]  RST_ADDR  = RST_ADDR_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    zxuno_regport_if.slave   bus,
    output logic [7:0]       zxuno_addr,
    output logic             zxuno_regrd,
    output logic             zxuno_regwr,
    output logic [7:0]       zxuno_wrdata
`ifdef ZXUNO_ADDR_AUTOINC_EN
    ,
    output logic             regaddr_autoinc_active
`endif
);

    logic sel_addr;
    logic sel_data;
    logic rd_fall;
    logic wr_fall;

    regport_state_t state;
    regport_state_t state_next;
    logic           addr_write;
    logic           data_write;

    assign sel_addr = !bus.iorq_n && bus.m1_n && (bus.a == ADDR_PORT);
    assign sel_data = !bus.iorq_n && bus.m1_n && (bus.a == DATA_PORT);

    zxuno_strobe_edge u_rd_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .strobe_n (bus.rd_n),
        .fall     (rd_fall)
    );

    zxuno_strobe_edge u_wr_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .strobe_n (bus.wr_n),
        .fall     (wr_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Only IDLE reacts to new strobe edges, so a long or overlapping
    // access produces exactly one strobe. Writes win over reads.
    always_comb begin
        state_next = state;
        addr_write = 1'b0;
        data_write = 1'b0;
        case (state)
            ST_IDLE: begin
                if (wr_fall && sel_addr) begin
                    addr_write = 1'b1;
                end else if (wr_fall && sel_data) begin
                    data_write = 1'b1;
                    state_next = ST_WPULSE;
                end else if (rd_fall && sel_data) begin
                    state_next = ST_RACTIVE;
                end
            end
            ST_WPULSE: begin
                state_next = ST_WWAIT;
            end
            ST_WWAIT: begin
                if (bus.wr_n || bus.iorq_n) begin
                    state_next = ST_IDLE;
                end
            end
            ST_RACTIVE: begin
                if (bus.rd_n || bus.iorq_n) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign zxuno_regwr = (state == ST_WPULSE);
    assign zxuno_regrd = (state == ST_RACTIVE);

`ifdef ZXUNO_ADDR_AUTOINC_EN
    logic xfer_done;

    assign xfer_done = (state == ST_WWAIT || state == ST_RACTIVE) && (state_next == ST_IDLE);

    // FEh arms auto-increment and leaves the latch alone; the latch then
    // steps once at the end of every data-port transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zxuno_addr             <= RST_ADDR;
            zxuno_wrdata           <= 8'h00;
            regaddr_autoinc_active <= 1'b0;
        end else begin
            if (data_write) begin
                zxuno_wrdata <= bus.din;
            end
            if (addr_write) begin
                if (bus.din == AUTOINC_SELECT) begin
                    regaddr_autoinc_active <= 1'b1;
                end else begin
                    regaddr_autoinc_active <= 1'b0;
                    zxuno_addr             <= bus.din;
                end
            end else if (xfer_done && regaddr_autoinc_active) begin
                zxuno_addr <= zxuno_addr + 8'd1;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zxuno_addr   <= RST_ADDR;
            zxuno_wrdata <= 8'h00;
        end else begin
            if (data_write) begin
                zxuno_wrdata <= bus.din;
            end
            if (addr_write) begin
                zxuno_addr <= bus.din;
            end
        end
    end
`endif

    // Address-port readback is combinational so it tracks rd_n directly.
    assign bus.oe   = sel_addr && !bus.rd_n;
    assign bus.dout = bus.oe ? zxuno_addr : 8'hFF;

endmodule
